// File: rtl/pc_sequencer.sv
// Fetch sequencer for the MIPS16 13-bit PC: owns the PC register, the instruction-memory
// fetch handshake and one-delay-slot branch/jump redirects. Optional trap support: PCSEQ_TRAP_EN.
module pc_sequencer #(
    parameter int unsigned          PC_W      = 13,
    parameter logic [PC_W-1:0]      RESET_VEC = 13'h0000
`ifdef PCSEQ_TRAP_EN
   ,parameter logic [PC_W-1:0]      TRAP_VEC  = 13'h1F00
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            halt,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fetch_ack,
    output logic [PC_W-1:0] curr_pc,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr_pc,
    output logic [15:0]     fetch_count,
    output logic [1:0]      seq_state
`ifdef PCSEQ_TRAP_EN
   ,input  logic            trap_req,
    output logic [PC_W-1:0] epc
`endif
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]      state;
    logic            pend;
    logic [PC_W-1:0] pend_addr;
    logic            in_fetch;
    logic            xfer;
    logic            redir;
    logic [PC_W-1:0] redir_addr;
    logic [PC_W-1:0] next_pc;

    assign in_fetch   = (state == ST_FETCH);
    assign fetch_req  = in_fetch && !stall;
    assign fetch_addr = curr_pc;
    assign seq_state  = state;
    assign xfer       = fetch_req && fetch_ack;
    assign redir      = in_fetch && (br_taken || jmp_valid);
    assign redir_addr = jmp_valid ? jmp_target : br_target;

    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    always_comb begin
        next_pc = curr_pc + 1'b1;
        if (pend)  next_pc = pend_addr;
        if (redir) next_pc = redir_addr;
    end

`ifdef PCSEQ_TRAP_EN
    logic trap_latched;
    logic boot_q;
    logic trap_active;
    logic take_trap;

    assign trap_active = trap_latched || trap_req;
    // A trap raised during BOOT is honoured on the very first FETCH cycle.
    assign take_trap   = trap_active &&
                         ((state == ST_HALTED) || (in_fetch && (xfer || stall || boot_q)));
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            curr_pc     <= RESET_VEC;
            pend        <= 1'b0;
            pend_addr   <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            fetch_count <= '0;
`ifdef PCSEQ_TRAP_EN
            epc          <= '0;
            trap_latched <= 1'b0;
            boot_q       <= 1'b0;
`endif
        end else begin
            instr_valid <= xfer;
            if (xfer) begin
                instr_pc <= curr_pc;
                if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            end

            case (state)
                ST_BOOT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (xfer) begin
                        curr_pc <= next_pc;
                        pend    <= 1'b0;
                    end else if (redir) begin
                        pend      <= 1'b1;
                        pend_addr <= redir_addr;
                    end
                    if (halt && (xfer || stall)) state <= ST_HALTED;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_BOOT;
            endcase

`ifdef PCSEQ_TRAP_EN
            // Later assignments here override the normal sequencing above.
            boot_q <= (state == ST_BOOT);
            if (take_trap) begin
                epc          <= xfer ? next_pc : curr_pc;
                curr_pc      <= TRAP_VEC;
                pend         <= 1'b0;
                state        <= ST_FETCH;
                trap_latched <= 1'b0;
            end else begin
                trap_latched <= trap_active;
            end
`endif
        end
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer for the MIPS16 core's 13-bit program counter. It owns the PC register and the instruction-memory fetch handshake. It selects each next fetch address from sequential increment, branch and jump redirects (one delay slot), and halt. It sits between the decode/hazard logic and the instruction memory and drives the PC value that the rest of the pipeline consumes.

## Interface
- PC_W, 13, program counter width (word address)
- RESET_VEC, 13'h0000, first fetch address after reset
- TRAP_VEC, 13'h1F00, trap handler address (used only with PCSEQ_TRAP_EN)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall from hazard unit; suppresses fetch_req
- br_taken  in  1  conditional branch resolved taken (single-cycle pulse)
- br_target  in  PC_W  branch target
- jmp_valid  in  1  jump/JR resolved (single-cycle pulse)
- jmp_target  in  PC_W  jump target
- halt  in  1  HALT decoded
- fetch_req  out  1  fetch request to instruction memory
- fetch_addr  out  PC_W  fetch address; equals curr_pc
- fetch_ack  in  1  memory accepts/returns the word; a transfer occurs when fetch_req && fetch_ack
- curr_pc  out  PC_W  current fetch PC
- instr_valid  out  1  registered pulse, one cycle after each transfer
- instr_pc  out  PC_W  address of the word flagged by instr_valid
- fetch_count  out  16  number of transfers since reset, saturating at 16'hFFFF
- seq_state  out  2  FSM state: 0 BOOT, 1 FETCH, 2 HALTED
- trap_req  in  1  external/illegal-op trap pulse (PCSEQ_TRAP_EN only)
- epc  out  PC_W  exception return PC (PCSEQ_TRAP_EN only)

## Operation
- Reset values: state BOOT, curr_pc=RESET_VEC, fetch_req=0, instr_valid=0, instr_pc=0, fetch_count=0, redirect pending=0, epc=0. rst overrides all other inputs, including mid-handshake.
- BOOT: lasts exactly one cycle with fetch_req=0, then goes to FETCH unconditionally.
- FETCH: fetch_req = !stall. fetch_addr is held stable until a transfer occurs.
- Redirect capture: a br_taken or jmp_valid pulse in FETCH loads a pending-redirect register (pend, pend_addr). If both pulses occur in the same cycle, jmp_target wins. A new redirect before the pending one is consumed overwrites it.
- Delay slot: the fetch in flight, or the next one if idle, completes normally. The redirect becomes the address of the following fetch. Words are never squashed.
- Next PC on a transfer, in priority order:
  - a redirect arriving in this cycle: its target;
  - pend: pend_addr, then pend is cleared;
  - otherwise curr_pc+1, modulo 2^PC_W, so 13'h1FFF wraps to 13'h0000.
- halt: at the first cycle where halt=1 and either a transfer occurs or fetch_req=0, the state moves to HALTED after that cycle's PC update. HALTED: fetch_req=0, curr_pc frozen, pend retained. HALTED is left only by rst, or by trap when enabled.
- fetch_count increments by 1 on every transfer.
- Redirect pulses that arrive while in BOOT or HALTED are ignored.

## Timing
- After rst deasserts: BOOT in cycle 0. In cycle 1, fetch_req=1 and fetch_addr=RESET_VEC (if stall=0).
- A zero-wait memory (fetch_ack tied high) gives one transfer per cycle; curr_pc advances every cycle.
- Redirect to fetch latency:
  - redirect in the same cycle as a transfer: target is fetched the next cycle;
  - redirect during a wait: target is fetched the cycle after the next transfer.
- instr_valid and instr_pc lag the transfer by exactly one cycle.
- stall asserted while fetch_ack is high: no transfer, and curr_pc holds.

## Configuration
- PCSEQ_TRAP_EN defined:
  - trap_req and epc ports exist.
  - trap_req is latched and takes top priority at the next transfer, or immediately if fetch_req=0 or the state is HALTED.
  - On taking the trap: epc <= the next PC that would otherwise have been selected, curr_pc <= TRAP_VEC, pend cleared, state FETCH.
  - A trap in BOOT is taken on the first FETCH cycle.
- PCSEQ_TRAP_EN undefined: the trap ports and logic are absent, and TRAP_VEC is unused.

## Test plan
- Reset, then zero-wait memory, 5 cycles: fetch_addr 0,1,2,3,4. instr_pc trails by one cycle. fetch_count=5.
- br_taken with br_target=13'h0040 coincident with the transfer at PC 3: next fetches 13'h0040, 13'h0041. At PC 3, with br_taken and jmp_valid (target 13'h0100) in the same cycle: next fetch is 13'h0100.
- fetch_ack delayed 3 cycles at PC 7, with jmp_valid (target 13'h0200) in the first wait cycle: PC 7 completes, then fetch_addr=13'h0200. fetch_addr stays at 7 throughout the wait.
- curr_pc=13'h1FFF with zero-wait memory: next fetch_addr=13'h0000. stall held 2 cycles: fetch_req=0 and curr_pc constant.
- halt at the PC 5 transfer: next PC 6 is held, seq_state=2, fetch_req=0. rst asserted mid-HALTED or mid-wait: all outputs return to their reset values next cycle.
- (PCSEQ_TRAP_EN) trap_req while fetching PC 10: epc=11, fetch_addr=13'h1F00. trap_req while HALTED at PC 6: epc=6, fetch resumes at 13'h1F00.
